// File: rtl/rob_module_pkg.sv
// Shared ROB types: entry, flag, FU and issue/commit bundles.
// Sizes are fixed here so every stage agrees on widths.
package data_structures;
    localparam int ROB_IDX_SIZE = 4;
    localparam int ROB_ENTRIES  = 2 ** ROB_IDX_SIZE;
    localparam int GPR_SIZE     = 64;
    localparam int GPR_IDX_SIZE = 5;
    localparam logic [ROB_IDX_SIZE:0] ROB_FULL_CNT =
        (ROB_IDX_SIZE + 1)'(ROB_ENTRIES);

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [1:0] {
        FU_ALU, FU_MEM, FU_BR, FU_MUL
    } fu_t;

    typedef logic [3:0] fu_op_t;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC,
        COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT,
        COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    typedef struct packed {
        logic                    valid;
        logic                    done;
        logic [GPR_IDX_SIZE-1:0] dst;
        logic                    set_nzcv;
        logic [GPR_SIZE-1:0]     value;
        nzcv_t                   nzcv;
    } rob_entry_t;

    typedef struct packed {
        logic                    done;
        logic                    src1_valid;
        logic [GPR_SIZE-1:0]     src1_value;
        logic [ROB_IDX_SIZE-1:0] src1_rob_index;
        logic                    src2_valid;
        logic [GPR_SIZE-1:0]     src2_value;
        logic [ROB_IDX_SIZE-1:0] src2_rob_index;
        logic                    nzcv_valid;
        nzcv_t                   nzcv_value;
        logic [ROB_IDX_SIZE-1:0] nzcv_rob_index;
        logic [ROB_IDX_SIZE-1:0] dst_rob_index;
        fu_t                     fu_id;
        fu_op_t                  fu_op;
        cond_t                   cond_codes;
        logic                    set_nzcv;
        logic                    instr_uses_nzcv;
    } rs_issue_t;

    typedef struct packed {
        logic                    should_commit;
        logic [GPR_SIZE-1:0]     value;
        logic [GPR_IDX_SIZE-1:0] reg_index;
        logic [ROB_IDX_SIZE-1:0] rob_index;
        logic                    set_nzcv;
        nzcv_t                   nzcv;
    } commit_t;

    function automatic logic [ROB_IDX_SIZE-1:0] rob_inc(
        input logic [ROB_IDX_SIZE-1:0] i
    );
        return i + ROB_IDX_SIZE'(1);
    endfunction
endpackage

// File: rtl/rob_module_forward.sv
// Per-operand forwarding mux: completed ROB entry first,
// then same-cycle FU broadcast, else the register-file operand.
import data_structures::*;

module rob_forward #(
    parameter int W = GPR_SIZE
) (
    input  logic                    i_in_valid,
    input  logic [W-1:0]            i_in_value,
    input  logic [ROB_IDX_SIZE-1:0] i_tag,
    input  logic                    i_ent_done,
    input  logic [W-1:0]            i_ent_value,
    input  logic                    i_fu_done,
    input  logic [ROB_IDX_SIZE-1:0] i_fu_tag,
    input  logic [W-1:0]            i_fu_value,
    output logic                    o_valid,
    output logic [W-1:0]            o_value
);
    always_comb begin
        o_valid = i_in_valid;
        o_value = i_in_value;
        if (!i_in_valid && i_ent_done) begin
            o_valid = 1'b1;
            o_value = i_ent_value;
        end else if (!i_in_valid && i_fu_done && i_fu_tag == i_tag) begin
            o_valid = 1'b1;
            o_value = i_fu_value;
        end
    end
endmodule

// File: rtl/rob_module.sv
// rob_module: 16-entry reorder buffer, registered issue to the
// reservation stations and in-order single-entry commit.
import data_structures::*;

module rob_module (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_reg_done,
    input  logic                    in_reg_src1_valid,
    input  logic                    in_reg_src2_valid,
    input  logic                    in_reg_nzcv_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_reg_src1_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_reg_src2_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_reg_nzcv_rob_index,
    input  logic [GPR_SIZE-1:0]     in_reg_src1_value,
    input  logic [GPR_SIZE-1:0]     in_reg_src2_value,
    input  nzcv_t                   in_reg_nzcv,
    input  logic [GPR_IDX_SIZE-1:0] in_reg_dst,
    input  logic                    in_reg_set_nzcv,
    input  logic                    in_reg_instr_uses_nzcv,
    input  fu_t                     in_reg_fu_id,
    input  fu_op_t                  in_reg_fu_op,
    input  cond_t                   in_reg_cond_codes,
    input  logic                    in_fu_done,
    input  logic [ROB_IDX_SIZE-1:0] in_fu_rob_index,
    input  logic [GPR_SIZE-1:0]     in_fu_value,
    input  logic                    in_fu_set_nzcv,
    input  nzcv_t                   in_fu_nzcv,
    output logic [ROB_IDX_SIZE-1:0] out_reg_next_rob_index,
    output logic                    out_reg_should_commit,
    output logic [GPR_SIZE-1:0]     out_reg_commit_value,
    output logic [GPR_IDX_SIZE-1:0] out_reg_reg_index,
    output logic [ROB_IDX_SIZE-1:0] out_reg_commit_rob_index,
    output logic                    out_reg_set_nzcv,
    output nzcv_t                   out_reg_nzcv,
    output logic                    out_d_stall,
    output logic                    out_rs_done,
    output logic                    out_rs_src1_valid,
    output logic [GPR_SIZE-1:0]     out_rs_src1_value,
    output logic [ROB_IDX_SIZE-1:0] out_rs_src1_rob_index,
    output logic                    out_rs_src2_valid,
    output logic [GPR_SIZE-1:0]     out_rs_src2_value,
    output logic [ROB_IDX_SIZE-1:0] out_rs_src2_rob_index,
    output logic                    out_rs_nzcv_valid,
    output nzcv_t                   out_rs_nzcv_value,
    output logic [ROB_IDX_SIZE-1:0] out_rs_nzcv_rob_index,
    output logic [ROB_IDX_SIZE-1:0] out_rs_dst_rob_index,
    output fu_t                     out_rs_fu_id,
    output fu_op_t                  out_rs_fu_op,
    output cond_t                   out_rs_cond_codes,
    output logic                    out_rs_set_nzcv,
    output logic                    out_rs_instr_uses_nzcv
);
    rob_entry_t              r_rob [ROB_ENTRIES];
    logic [ROB_IDX_SIZE-1:0] r_head;
    logic [ROB_IDX_SIZE-1:0] r_tail;
    logic [ROB_IDX_SIZE:0]   r_count;
    rs_issue_t               r_issue;
    commit_t                 r_commit;

    rob_entry_t          w_head;
    rob_entry_t          w_e1;
    rob_entry_t          w_e2;
    rob_entry_t          w_en;
    logic                w_full;
    logic                w_commit;
    logic                w_alloc;
    logic                w_s1_valid;
    logic                w_s2_valid;
    logic                w_nz_valid;
    logic [GPR_SIZE-1:0] w_s1_value;
    logic [GPR_SIZE-1:0] w_s2_value;
    nzcv_t               w_nz_value;

    assign w_head = r_rob[r_head];
    assign w_e1   = r_rob[in_reg_src1_rob_index];
    assign w_e2   = r_rob[in_reg_src2_rob_index];
    assign w_en   = r_rob[in_reg_nzcv_rob_index];

    // Full is judged by count alone; head==tail is ambiguous.
    assign w_full   = (r_count == ROB_FULL_CNT);
    assign w_commit = w_head.valid && w_head.done;
    // A commit frees the head slot this cycle, so a full ROB still accepts.
    assign w_alloc  = in_reg_done && (!w_full || w_commit);

    rob_forward #(.W(GPR_SIZE)) u_fwd_src1 (
        .i_in_valid  (in_reg_src1_valid),
        .i_in_value  (in_reg_src1_value),
        .i_tag       (in_reg_src1_rob_index),
        .i_ent_done  (w_e1.done),
        .i_ent_value (w_e1.value),
        .i_fu_done   (in_fu_done),
        .i_fu_tag    (in_fu_rob_index),
        .i_fu_value  (in_fu_value),
        .o_valid     (w_s1_valid),
        .o_value     (w_s1_value)
    );

    rob_forward #(.W(GPR_SIZE)) u_fwd_src2 (
        .i_in_valid  (in_reg_src2_valid),
        .i_in_value  (in_reg_src2_value),
        .i_tag       (in_reg_src2_rob_index),
        .i_ent_done  (w_e2.done),
        .i_ent_value (w_e2.value),
        .i_fu_done   (in_fu_done),
        .i_fu_tag    (in_fu_rob_index),
        .i_fu_value  (in_fu_value),
        .o_valid     (w_s2_valid),
        .o_value     (w_s2_value)
    );

    rob_forward #(.W(4)) u_fwd_nzcv (
        .i_in_valid  (in_reg_nzcv_valid),
        .i_in_value  (in_reg_nzcv),
        .i_tag       (in_reg_nzcv_rob_index),
        .i_ent_done  (w_en.done),
        .i_ent_value (w_en.nzcv),
        .i_fu_done   (in_fu_done),
        .i_fu_tag    (in_fu_rob_index),
        .i_fu_value  (in_fu_nzcv),
        .o_valid     (w_nz_valid),
        .o_value     (w_nz_value)
    );

    // Later assignments win: commit clears, then dispatch refills.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                r_rob[i] <= '0;
            end
        end else begin
            if (in_fu_done && r_rob[in_fu_rob_index].valid) begin
                r_rob[in_fu_rob_index].done  <= 1'b1;
                r_rob[in_fu_rob_index].value <= in_fu_value;
                if (in_fu_set_nzcv) begin
                    r_rob[in_fu_rob_index].nzcv <= in_fu_nzcv;
                end
            end
            if (w_commit) begin
                r_rob[r_head] <= '0;
                r_head        <= rob_inc(r_head);
            end
            if (w_alloc) begin
                r_rob[r_tail] <= '{
                    valid:    1'b1,
                    done:     1'b0,
                    dst:      in_reg_dst,
                    set_nzcv: in_reg_set_nzcv,
                    value:    '0,
                    nzcv:     '0
                };
                r_tail <= rob_inc(r_tail);
            end
            unique case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + (ROB_IDX_SIZE + 1)'(1);
                2'b01:   r_count <= r_count - (ROB_IDX_SIZE + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_issue  <= '0;
            r_commit <= '0;
        end else begin
            r_issue <= '{
                done:            w_alloc,
                src1_valid:      w_s1_valid,
                src1_value:      w_s1_value,
                src1_rob_index:  in_reg_src1_rob_index,
                src2_valid:      w_s2_valid,
                src2_value:      w_s2_value,
                src2_rob_index:  in_reg_src2_rob_index,
                nzcv_valid:      w_nz_valid,
                nzcv_value:      w_nz_value,
                nzcv_rob_index:  in_reg_nzcv_rob_index,
                dst_rob_index:   r_tail,
                fu_id:           in_reg_fu_id,
                fu_op:           in_reg_fu_op,
                cond_codes:      in_reg_cond_codes,
                set_nzcv:        in_reg_set_nzcv,
                instr_uses_nzcv: in_reg_instr_uses_nzcv
            };
            r_commit <= '{
                should_commit: w_commit,
                value:         w_head.value,
                reg_index:     w_head.dst,
                rob_index:     r_head,
                set_nzcv:      w_head.set_nzcv,
                nzcv:          w_head.nzcv
            };
        end
    end

    assign out_reg_next_rob_index   = r_tail;
    assign out_d_stall              = w_full;
    assign out_reg_should_commit    = r_commit.should_commit;
    assign out_reg_commit_value     = r_commit.value;
    assign out_reg_reg_index        = r_commit.reg_index;
    assign out_reg_commit_rob_index = r_commit.rob_index;
    assign out_reg_set_nzcv         = r_commit.set_nzcv;
    assign out_reg_nzcv             = r_commit.nzcv;
    assign out_rs_done              = r_issue.done;
    assign out_rs_src1_valid        = r_issue.src1_valid;
    assign out_rs_src1_value        = r_issue.src1_value;
    assign out_rs_src1_rob_index    = r_issue.src1_rob_index;
    assign out_rs_src2_valid        = r_issue.src2_valid;
    assign out_rs_src2_value        = r_issue.src2_value;
    assign out_rs_src2_rob_index    = r_issue.src2_rob_index;
    assign out_rs_nzcv_valid        = r_issue.nzcv_valid;
    assign out_rs_nzcv_value        = r_issue.nzcv_value;
    assign out_rs_nzcv_rob_index    = r_issue.nzcv_rob_index;
    assign out_rs_dst_rob_index     = r_issue.dst_rob_index;
    assign out_rs_fu_id             = r_issue.fu_id;
    assign out_rs_fu_op             = r_issue.fu_op;
    assign out_rs_cond_codes        = r_issue.cond_codes;
    assign out_rs_set_nzcv          = r_issue.set_nzcv;
    assign out_rs_instr_uses_nzcv   = r_issue.instr_uses_nzcv;
endmodule

// File: tb/tb_rob_module.sv
// Bench for rob_module: forwarding table, directed corner sequences
// and a random run against a queue-based reorder buffer model.
module tb_rob_module;
    import data_structures::*;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_reg_done;
    logic        in_reg_src1_valid, in_reg_src2_valid, in_reg_nzcv_valid;
    logic [3:0]  in_reg_src1_rob_index, in_reg_src2_rob_index;
    logic [3:0]  in_reg_nzcv_rob_index;
    logic [63:0] in_reg_src1_value, in_reg_src2_value;
    nzcv_t       in_reg_nzcv;
    logic [4:0]  in_reg_dst;
    logic        in_reg_set_nzcv, in_reg_instr_uses_nzcv;
    fu_t         in_reg_fu_id;
    fu_op_t      in_reg_fu_op;
    cond_t       in_reg_cond_codes;
    logic        in_fu_done;
    logic [3:0]  in_fu_rob_index;
    logic [63:0] in_fu_value;
    logic        in_fu_set_nzcv;
    nzcv_t       in_fu_nzcv;
    logic [3:0]  out_reg_next_rob_index;
    logic        out_reg_should_commit;
    logic [63:0] out_reg_commit_value;
    logic [4:0]  out_reg_reg_index;
    logic [3:0]  out_reg_commit_rob_index;
    logic        out_reg_set_nzcv;
    nzcv_t       out_reg_nzcv;
    logic        out_d_stall;
    logic        out_rs_done;
    logic        out_rs_src1_valid, out_rs_src2_valid, out_rs_nzcv_valid;
    logic [63:0] out_rs_src1_value, out_rs_src2_value;
    logic [3:0]  out_rs_src1_rob_index, out_rs_src2_rob_index;
    nzcv_t       out_rs_nzcv_value;
    logic [3:0]  out_rs_nzcv_rob_index, out_rs_dst_rob_index;
    fu_t         out_rs_fu_id;
    fu_op_t      out_rs_fu_op;
    cond_t       out_rs_cond_codes;
    logic        out_rs_set_nzcv, out_rs_instr_uses_nzcv;

    rob_module dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_reg_done(in_reg_done),
        .in_reg_src1_valid(in_reg_src1_valid),
        .in_reg_src2_valid(in_reg_src2_valid),
        .in_reg_nzcv_valid(in_reg_nzcv_valid),
        .in_reg_src1_rob_index(in_reg_src1_rob_index),
        .in_reg_src2_rob_index(in_reg_src2_rob_index),
        .in_reg_nzcv_rob_index(in_reg_nzcv_rob_index),
        .in_reg_src1_value(in_reg_src1_value),
        .in_reg_src2_value(in_reg_src2_value),
        .in_reg_nzcv(in_reg_nzcv), .in_reg_dst(in_reg_dst),
        .in_reg_set_nzcv(in_reg_set_nzcv),
        .in_reg_instr_uses_nzcv(in_reg_instr_uses_nzcv),
        .in_reg_fu_id(in_reg_fu_id), .in_reg_fu_op(in_reg_fu_op),
        .in_reg_cond_codes(in_reg_cond_codes),
        .in_fu_done(in_fu_done), .in_fu_rob_index(in_fu_rob_index),
        .in_fu_value(in_fu_value), .in_fu_set_nzcv(in_fu_set_nzcv),
        .in_fu_nzcv(in_fu_nzcv),
        .out_reg_next_rob_index(out_reg_next_rob_index),
        .out_reg_should_commit(out_reg_should_commit),
        .out_reg_commit_value(out_reg_commit_value),
        .out_reg_reg_index(out_reg_reg_index),
        .out_reg_commit_rob_index(out_reg_commit_rob_index),
        .out_reg_set_nzcv(out_reg_set_nzcv), .out_reg_nzcv(out_reg_nzcv),
        .out_d_stall(out_d_stall), .out_rs_done(out_rs_done),
        .out_rs_src1_valid(out_rs_src1_valid),
        .out_rs_src1_value(out_rs_src1_value),
        .out_rs_src1_rob_index(out_rs_src1_rob_index),
        .out_rs_src2_valid(out_rs_src2_valid),
        .out_rs_src2_value(out_rs_src2_value),
        .out_rs_src2_rob_index(out_rs_src2_rob_index),
        .out_rs_nzcv_valid(out_rs_nzcv_valid),
        .out_rs_nzcv_value(out_rs_nzcv_value),
        .out_rs_nzcv_rob_index(out_rs_nzcv_rob_index),
        .out_rs_dst_rob_index(out_rs_dst_rob_index),
        .out_rs_fu_id(out_rs_fu_id), .out_rs_fu_op(out_rs_fu_op),
        .out_rs_cond_codes(out_rs_cond_codes),
        .out_rs_set_nzcv(out_rs_set_nzcv),
        .out_rs_instr_uses_nzcv(out_rs_instr_uses_nzcv)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        v;
        logic [3:0]  t;
        logic [63:0] val;
        logic        fd;
        logic [3:0]  ft;
        logic [63:0] fv;
        logic        ev;
        logic [63:0] eval;
    } vec_t;
    vec_t vt[5];

    // Pending instructions in program order; front is the oldest.
    typedef struct {
        int         idx;
        logic [4:0] dst;
        logic       setf;
        logic       done;
        logic [63:0] val;
        logic [3:0] nz;
    } pe_t;
    pe_t q[$];
    int  m_tail;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        @(negedge in_clk);
    endtask

    task automatic idle();
        in_reg_done = 0;
        in_reg_src1_valid = 0; in_reg_src2_valid = 0; in_reg_nzcv_valid = 0;
        in_reg_src1_rob_index = 0; in_reg_src2_rob_index = 0;
        in_reg_nzcv_rob_index = 0;
        in_reg_src1_value = 0; in_reg_src2_value = 0; in_reg_nzcv = '0;
        in_reg_dst = 0; in_reg_set_nzcv = 0; in_reg_instr_uses_nzcv = 0;
        in_reg_fu_id = FU_ALU; in_reg_fu_op = '0;
        in_reg_cond_codes = COND_EQ;
        in_fu_done = 0; in_fu_rob_index = 0; in_fu_value = 0;
        in_fu_set_nzcv = 0; in_fu_nzcv = '0;
    endtask

    task automatic do_reset();
        idle();
        in_rst = 1;
        tick();
        in_rst = 0;
    endtask

    task automatic fu_wr(input logic [3:0] idx, input logic [63:0] v,
                         input logic [3:0] nz);
        in_fu_done = 1; in_fu_rob_index = idx; in_fu_value = v;
        in_fu_set_nzcv = 1; in_fu_nzcv = nzcv_t'(nz);
    endtask

    function automatic logic [64:0] m_fwd(input logic v,
        input logic [3:0] t, input logic [63:0] val, input logic nz);
        if (!v) begin
            foreach (q[k]) begin
                if (q[k].idx == int'(t) && q[k].done)
                    return {1'b1, nz ? {60'b0, q[k].nz} : q[k].val};
            end
            if (in_fu_done && in_fu_rob_index == t)
                return {1'b1, nz ? {60'b0, 4'(in_fu_nzcv)} : in_fu_value};
        end
        return {v, val};
    endfunction

    function automatic logic [3:0] pick_tag(input logic v);
        logic [3:0] t;
        if (q.size() > 0 && $urandom_range(0, 1) == 1)
            t = 4'(q[$urandom_range(0, q.size() - 1)].idx);
        else
            t = 4'($urandom_range(0, 15));
        if (v && in_fu_done && t == in_fu_rob_index) t = t + 4'd1;
        return t;
    endfunction

    task automatic run_random(input int n);
        logic        full, cmt, acc;
        logic [64:0] e1, e2, en;
        pe_t         eh;
        int          ei, pd;
        for (int c = 0; c < n; c++) begin
            pd = ((c / 200) % 2 == 1) ? 85 : 35;
            in_reg_done = ($urandom_range(0, 99) < pd);
            in_reg_dst = 5'($urandom_range(0, 31));
            in_reg_set_nzcv = 1'($urandom_range(0, 1));
            in_reg_instr_uses_nzcv = 1'($urandom_range(0, 1));
            in_reg_fu_id = fu_t'($urandom_range(0, 3));
            in_reg_fu_op = 4'($urandom_range(0, 15));
            in_reg_cond_codes = cond_t'($urandom_range(0, 15));
            in_fu_done = ($urandom_range(0, 99) < 50);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                in_fu_rob_index = 4'(q[$urandom_range(0, q.size() - 1)].idx);
            else
                in_fu_rob_index = 4'($urandom_range(0, 15));
            in_fu_value = {$urandom, $urandom};
            in_fu_set_nzcv = 1'($urandom_range(0, 1));
            in_fu_nzcv = nzcv_t'(4'($urandom_range(0, 15)));
            in_reg_src1_valid = ($urandom_range(0, 2) == 0);
            in_reg_src2_valid = ($urandom_range(0, 2) == 0);
            in_reg_nzcv_valid = ($urandom_range(0, 2) == 0);
            in_reg_src1_rob_index = pick_tag(in_reg_src1_valid);
            in_reg_src2_rob_index = pick_tag(in_reg_src2_valid);
            in_reg_nzcv_rob_index = pick_tag(in_reg_nzcv_valid);
            in_reg_src1_value = {$urandom, $urandom};
            in_reg_src2_value = {$urandom, $urandom};
            in_reg_nzcv = nzcv_t'(4'($urandom_range(0, 15)));

            full = (q.size() == 16);
            cmt = (q.size() > 0) && q[0].done;
            acc = in_reg_done && (!full || cmt);
            if (cmt) eh = q[0];
            e1 = m_fwd(in_reg_src1_valid, in_reg_src1_rob_index,
                       in_reg_src1_value, 1'b0);
            e2 = m_fwd(in_reg_src2_valid, in_reg_src2_rob_index,
                       in_reg_src2_value, 1'b0);
            en = m_fwd(in_reg_nzcv_valid, in_reg_nzcv_rob_index,
                       {60'b0, 4'(in_reg_nzcv)}, 1'b1);
            ei = m_tail;

            tick();

            chk("rnd_commit", out_reg_should_commit, cmt);
            if (cmt) begin
                chk("rnd_cval", out_reg_commit_value, eh.val);
                chk("rnd_cdst", out_reg_reg_index, eh.dst);
                chk("rnd_cidx", out_reg_commit_rob_index, eh.idx);
                chk("rnd_cset", out_reg_set_nzcv, eh.setf);
                chk("rnd_cnz", out_reg_nzcv, eh.nz);
            end
            chk("rnd_rs_done", out_rs_done, acc);
            if (acc) begin
                chk("rnd_s1v", out_rs_src1_valid, e1[64]);
                chk("rnd_s1", out_rs_src1_value, e1[63:0]);
                chk("rnd_s2v", out_rs_src2_valid, e2[64]);
                chk("rnd_s2", out_rs_src2_value, e2[63:0]);
                chk("rnd_nzv", out_rs_nzcv_valid, en[64]);
                chk("rnd_nz", out_rs_nzcv_value, en[63:0]);
                chk("rnd_s1t", out_rs_src1_rob_index, in_reg_src1_rob_index);
                chk("rnd_dsti", out_rs_dst_rob_index, ei);
                chk("rnd_fu", out_rs_fu_id, in_reg_fu_id);
                chk("rnd_op", out_rs_fu_op, in_reg_fu_op);
                chk("rnd_cc", out_rs_cond_codes, in_reg_cond_codes);
                chk("rnd_set", out_rs_set_nzcv, in_reg_set_nzcv);
                chk("rnd_use", out_rs_instr_uses_nzcv, in_reg_instr_uses_nzcv);
            end

            if (in_fu_done) begin
                foreach (q[k]) begin
                    if (q[k].idx == int'(in_fu_rob_index)) begin
                        q[k].done = 1;
                        q[k].val = in_fu_value;
                        if (in_fu_set_nzcv) q[k].nz = in_fu_nzcv;
                    end
                end
            end
            if (cmt) void'(q.pop_front());
            if (acc) begin
                q.push_back('{m_tail, in_reg_dst, in_reg_set_nzcv,
                              1'b0, 64'd0, 4'd0});
                m_tail = (m_tail + 1) % 16;
            end
            chk("rnd_stall", out_d_stall, q.size() == 16);
            chk("rnd_next", out_reg_next_rob_index, m_tail);
        end
    endtask

    initial begin
        vt[0] = '{0, 4'd3, 64'd11, 1, 4'd3, 64'd42, 1, 64'd42};
        vt[1] = '{0, 4'd3, 64'd11, 1, 4'd4, 64'd42, 0, 64'd11};
        vt[2] = '{1, 4'd3, 64'd13, 1, 4'd5, 64'd42, 1, 64'd13};
        vt[3] = '{0, 4'd7, 64'd99, 0, 4'd7, 64'd42, 0, 64'd99};
        vt[4] = '{0, 4'd15, 64'd1, 1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF,
                  1, 64'hFFFF_FFFF_FFFF_FFFF};

        do_reset();
        chk("rst_commit", out_reg_should_commit, 0);
        chk("rst_cval", out_reg_commit_value, 0);
        chk("rst_rs_done", out_rs_done, 0);
        chk("rst_rs_dst", out_rs_dst_rob_index, 0);
        chk("rst_stall", out_d_stall, 0);
        chk("rst_next", out_reg_next_rob_index, 0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            in_reg_done = 1; in_reg_dst = 5'(i + 1);
            in_reg_src1_valid = vt[i].v; in_reg_src1_rob_index = vt[i].t;
            in_reg_src1_value = vt[i].val;
            in_reg_src2_valid = vt[i].v; in_reg_src2_rob_index = vt[i].t;
            in_reg_src2_value = vt[i].val;
            in_reg_nzcv_valid = vt[i].v; in_reg_nzcv_rob_index = vt[i].t;
            in_reg_nzcv = nzcv_t'(vt[i].val[3:0]);
            in_fu_done = vt[i].fd; in_fu_rob_index = vt[i].ft;
            in_fu_value = vt[i].fv; in_fu_set_nzcv = 1;
            in_fu_nzcv = nzcv_t'(vt[i].fv[3:0]);
            tick();
            idle();
            chk("tbl_done", out_rs_done, 1);
            chk("tbl_s1v", out_rs_src1_valid, vt[i].ev);
            chk("tbl_s1", out_rs_src1_value, vt[i].eval);
            chk("tbl_s2v", out_rs_src2_valid, vt[i].ev);
            chk("tbl_s2", out_rs_src2_value, vt[i].eval);
            chk("tbl_nzv", out_rs_nzcv_valid, vt[i].ev);
            chk("tbl_nz", out_rs_nzcv_value, vt[i].eval[3:0]);
            chk("tbl_dsti", out_rs_dst_rob_index, 0);
        end

        // First dispatch, then fill, then overflow, then full commit+dispatch
        do_reset();
        in_reg_done = 1; in_reg_dst = 5'd1;
        chk("d1_next_pre", out_reg_next_rob_index, 0);
        tick();
        chk("d1_rs_done", out_rs_done, 1);
        chk("d1_dsti", out_rs_dst_rob_index, 0);
        chk("d1_next", out_reg_next_rob_index, 1);
        for (int k = 2; k <= 16; k++) begin
            in_reg_dst = 5'(k);
            tick();
            chk("fill_stall", out_d_stall, k == 16);
        end
        chk("fill_next", out_reg_next_rob_index, 0);
        tick();
        chk("drop_rs_done", out_rs_done, 0);
        chk("drop_next", out_reg_next_rob_index, 0);
        chk("drop_stall", out_d_stall, 1);
        idle();
        fu_wr(4'd0, 64'd9, 4'd1);
        tick();
        chk("full_wb_commit", out_reg_should_commit, 0);
        idle();
        in_reg_done = 1; in_reg_dst = 5'd7;
        tick();
        idle();
        chk("fc_commit", out_reg_should_commit, 1);
        chk("fc_cidx", out_reg_commit_rob_index, 0);
        chk("fc_cval", out_reg_commit_value, 9);
        chk("fc_rs_done", out_rs_done, 1);
        chk("fc_dsti", out_rs_dst_rob_index, 0);
        chk("fc_next", out_reg_next_rob_index, 1);
        chk("fc_stall", out_d_stall, 1);
        tick();
        chk("fc_nocommit", out_reg_should_commit, 0);
        chk("fc_stall2", out_d_stall, 1);

        // Out-of-order writeback, forwarding from entry and FU, in-order commit
        do_reset();
        in_reg_done = 1; in_reg_dst = 5'd2;
        tick();
        in_reg_dst = 5'd3;
        tick();
        idle();
        fu_wr(4'd1, 64'd7, 4'h2);
        tick();
        chk("ooo_wait", out_reg_should_commit, 0);
        in_fu_done = 0;
        in_reg_done = 1; in_reg_dst = 5'd4; in_reg_instr_uses_nzcv = 1;
        in_reg_src1_rob_index = 4'd1; in_reg_src2_rob_index = 4'd0;
        in_reg_nzcv_rob_index = 4'd0;
        fu_wr(4'd0, 64'd5, 4'h8);
        tick();
        idle();
        chk("fw_done", out_rs_done, 1);
        chk("fw_dsti", out_rs_dst_rob_index, 2);
        chk("fw_s1v", out_rs_src1_valid, 1);
        chk("fw_s1", out_rs_src1_value, 7);
        chk("fw_s2v", out_rs_src2_valid, 1);
        chk("fw_s2", out_rs_src2_value, 5);
        chk("fw_nzv", out_rs_nzcv_valid, 1);
        chk("fw_nz", out_rs_nzcv_value, 4'h8);
        chk("ooo_wait2", out_reg_should_commit, 0);
        tick();
        chk("c0_commit", out_reg_should_commit, 1);
        chk("c0_val", out_reg_commit_value, 5);
        chk("c0_idx", out_reg_commit_rob_index, 0);
        chk("c0_dst", out_reg_reg_index, 2);
        chk("c0_nz", out_reg_nzcv, 4'h8);
        chk("c0_set", out_reg_set_nzcv, 0);
        tick();
        chk("c1_commit", out_reg_should_commit, 1);
        chk("c1_val", out_reg_commit_value, 7);
        chk("c1_idx", out_reg_commit_rob_index, 1);
        chk("c1_dst", out_reg_reg_index, 3);
        chk("c1_nz", out_reg_nzcv, 4'h2);
        tick();
        chk("c2_commit", out_reg_should_commit, 0);

        // Reset with five pending entries, head ready to commit
        do_reset();
        in_reg_done = 1;
        for (int k = 0; k < 5; k++) begin
            in_reg_dst = 5'(k + 8);
            tick();
        end
        idle();
        fu_wr(4'd0, 64'd3, 4'h0);
        tick();
        idle();
        in_rst = 1;
        tick();
        in_rst = 0;
        chk("mr_rst_commit", out_reg_should_commit, 0);
        for (int k = 1; k <= 4; k++) begin
            fu_wr(4'(k), 64'(k), 4'h0);
            tick();
            chk("mr_nocommit", out_reg_should_commit, 0);
        end
        idle();
        chk("mr_next", out_reg_next_rob_index, 0);
        chk("mr_stall", out_d_stall, 0);
        in_reg_done = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) chk("mr_dsti", out_rs_dst_rob_index, 0);
            if (k == 15) chk("mr_stall15", out_d_stall, 0);
            if (k == 16) chk("mr_stall16", out_d_stall, 1);
        end

        do_reset();
        q.delete();
        m_tail = 0;
        run_random(3000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
